// File: rtl/bus_timer_multi_pkg.sv
// Shared definitions for the multi-channel bus timer: bus layout, register map, CTRL bits.
package bus_timer_multi_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rd_req;
    logic        wr_req;
  } bus_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        rd_ack;
    logic        wr_ack;
  } bus_rsp_t;

  localparam int BUS_IN_WIDTH  = $bits(bus_req_t);
  localparam int BUS_OUT_WIDTH = $bits(bus_rsp_t);

  localparam logic [7:0] REG_STATUS   = 8'h00;
  localparam logic [7:0] REG_PRESCALE = 8'h04;
  localparam logic [7:0] REG_COUNTER  = 8'h08;
  localparam logic [7:0] CH_BASE      = 8'h10;
  localparam logic [7:0] CH_STRIDE    = 8'h10;
  localparam logic [3:0] CH_CTRL      = 4'h0;
  localparam logic [3:0] CH_LOAD      = 4'h4;
  localparam logic [3:0] CH_COUNT     = 4'h8;

  localparam int CTRL_EN           = 0;
  localparam int CTRL_PERIODIC     = 1;
  localparam int CTRL_IRQ_EN       = 2;
  localparam int CTRL_USE_PRESCALE = 3;

  // Member order puts en at bit 0, matching the CTRL register layout.
  typedef struct packed {
    logic use_prescale;
    logic irq_en;
    logic periodic;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/bus_timer_multi_chan.sv
// One timer channel: CTRL/LOAD registers, down-counter and single-cycle expiry pulse.
import bus_timer_multi_pkg::*;

module timer_chan #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_p,
  input  logic             ctrl_we,
  input  ctrl_t            ctrl_wdata,
  input  logic             load_we,
  input  logic [WIDTH-1:0] load_wdata,
  output ctrl_t            ctrl,
  output logic [WIDTH-1:0] load,
  output logic [WIDTH-1:0] count,
  output logic             expire
);

  logic tick;

  assign tick   = ctrl.use_prescale ? tick_p : 1'b1;
  assign expire = ctrl.en && tick && (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl  <= '0;
      load  <= '0;
      count <= '0;
    end else begin
      if (load_we) load <= load_wdata;
      if (ctrl_we) ctrl <= ctrl_wdata;
      // Expiry takes precedence over a concurrent CTRL write; a one-shot drops en.
      if (expire) begin
        if (ctrl.periodic) count <= load;
        else               ctrl.en <= 1'b0;
      end else if (ctrl_we && ctrl_wdata.en && !ctrl.en) begin
        count <= load;
      end else if (ctrl.en && tick) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_timer_multi.sv
// Multi-channel timer peripheral: bus decode, shared prescaler, pending/W1C status, free-running counter.
import bus_timer_multi_pkg::*;

module bus_timer_multi #(
  parameter logic [31:0] BUS_ADDR       = 32'h0200_0100,
  parameter int          NCHAN          = 4,
  parameter int          WIDTH          = 32,
  parameter int          PRESCALE_WIDTH = 16
) (
  input  logic                     bus_clk,
  input  logic                     bus_reset,
  input  logic [BUS_IN_WIDTH-1:0]  bus_in,
  output logic [BUS_OUT_WIDTH-1:0] bus_out,
  output logic [NCHAN-1:0]         irq,
  output logic                     irq_any
);

  bus_req_t req;
  bus_rsp_t rsp;
  logic [7:0] off;
  logic [3:0] slot, sub;
  logic       hit, wr, rd;

  assign req  = bus_in;
  assign hit  = (req.addr[31:8] == BUS_ADDR[31:8]);
  assign off  = req.addr[7:0];
  assign slot = off[7:4];
  assign sub  = off[3:0];
  assign wr   = hit && req.wr_req;
  assign rd   = hit && req.rd_req;

  logic [PRESCALE_WIDTH-1:0] prescale, pcnt, psc_m;
  logic [31:0]               counter;
  logic [NCHAN-1:0]          pending, expire, clr;
  logic                      tick_p, psc_we;

  ctrl_t [NCHAN-1:0]            ctrl_q;
  logic  [NCHAN-1:0][WIDTH-1:0] load_q, count_q;

  assign tick_p = (pcnt == prescale);
  assign psc_we = wr && (off == REG_PRESCALE);

  always_comb begin
    psc_m = prescale;
    for (int i = 0; i < PRESCALE_WIDTH; i++)
      if (req.be[i/8]) psc_m[i] = req.wdata[i];
  end

  always_comb begin
    clr = '0;
    if (wr && (off == REG_STATUS))
      for (int i = 0; i < NCHAN; i++) clr[i] = req.wdata[i] & req.be[0];
  end

  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      prescale <= '0;
      pcnt     <= '0;
      counter  <= '0;
      pending  <= '0;
    end else begin
      counter <= counter + 32'd1;
      // Expiry set beats a same-cycle W1C clear.
      pending <= (pending & ~clr) | expire;
      if (psc_we) begin
        prescale <= psc_m;
        pcnt     <= '0;
      end else begin
        pcnt <= tick_p ? '0 : pcnt + 1'b1;
      end
    end
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    logic       ctrl_we, load_we;
    ctrl_t      ctrl_m;
    logic [WIDTH-1:0] load_m;

    assign ctrl_we = wr && (slot == 4'(c + 1)) && (sub == CH_CTRL);
    assign load_we = wr && (slot == 4'(c + 1)) && (sub == CH_LOAD);
    assign ctrl_m  = req.be[0] ? ctrl_t'(req.wdata[3:0]) : ctrl_q[c];

    always_comb begin
      load_m = load_q[c];
      for (int i = 0; i < WIDTH; i++)
        if (req.be[i/8]) load_m[i] = req.wdata[i];
    end

    timer_chan #(.WIDTH(WIDTH)) u_chan (
      .clk        (bus_clk),
      .reset      (bus_reset),
      .tick_p     (tick_p),
      .ctrl_we    (ctrl_we),
      .ctrl_wdata (ctrl_m),
      .load_we    (load_we),
      .load_wdata (load_m),
      .ctrl       (ctrl_q[c]),
      .load       (load_q[c]),
      .count      (count_q[c]),
      .expire     (expire[c])
    );

    assign irq[c] = pending[c] & ctrl_q[c].irq_en;
  end

  assign irq_any = |irq;

  logic [31:0] rdata_n;

  always_comb begin
    rdata_n = '0;
    if (off == REG_STATUS)        rdata_n[NCHAN-1:0] = pending;
    else if (off == REG_PRESCALE) rdata_n[PRESCALE_WIDTH-1:0] = prescale;
    else if (off == REG_COUNTER)  rdata_n = counter;
    else begin
      for (int c = 0; c < NCHAN; c++) begin
        if (slot == 4'(c + 1)) begin
          case (sub)
            CH_CTRL:  rdata_n[3:0]       = ctrl_q[c];
            CH_LOAD:  rdata_n[WIDTH-1:0] = load_q[c];
            CH_COUNT: rdata_n[WIDTH-1:0] = count_q[c];
            default:  ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      rsp <= '0;
    end else begin
      rsp.rd_ack <= rd;
      rsp.wr_ack <= wr;
      rsp.rdata  <= rd ? rdata_n : 32'd0;
    end
  end

  assign bus_out = rsp;

endmodule
